// File: rtl/cqu_mips_pkg.sv
// Shared cqu_mips definitions: mul/div sequencer state encoding and
// pipeline constants used by the ID-stage hazard logic.
package cqu_mips_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int unsigned MD_LAT_DEFAULT = 4;

endpackage

// File: rtl/id_hazard_ctrl_fwd_unit.sv
// Operand bypass selector for one ID source register: EX result wins over
// MEM result, loads in EX are never bypassed, and $0 is never bypassed.
module fwd_unit
    import cqu_mips_pkg::*;
(
    input  logic [4:0]  src,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    input  logic [31:0] ex_result,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dst,
    input  logic [31:0] mem_result,
    output logic [31:0] fwd_data,
    output logic        fwd_sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_reg_write & ~ex_mem_read & (ex_dst != REG_ZERO) & (ex_dst == src);
    assign mem_hit = mem_reg_write & (mem_dst != REG_ZERO) & (mem_dst == src);

    always_comb begin
        fwd_data = '0;
        fwd_sel  = 1'b0;
        if (ex_hit) begin
            fwd_data = ex_result;
            fwd_sel  = 1'b1;
        end else if (mem_hit) begin
            fwd_data = mem_result;
            fwd_sel  = 1'b1;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage interlock and forwarding controller: load-use and mul/div
// hazard stalls, operand bypass selection, and the mul/div busy sequencer.
module id_hazard_ctrl
    import cqu_mips_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEFAULT,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_md,
    input  logic             id_reads_hilo,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dst,
    input  logic [31:0]      ex_result,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_dst,
    input  logic [31:0]      mem_result,
    output logic             stall,
    output logic             bubble,
    output logic [31:0]      forward_a,
    output logic [31:0]      forward_b,
    output logic             forward_a_sel,
    output logic             forward_b_sel,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    md_state_e  state;
    md_state_e  state_nx;
    logic [3:0] md_cnt;
    logic [3:0] md_cnt_nx;
    logic       lu;
    logic       mdh;
    logic       md_issue;

    assign lu = id_valid & ex_mem_read & ex_reg_write & (ex_dst != REG_ZERO)
              & ((id_uses_rs & (id_rs == ex_dst)) | (id_uses_rt & (id_rt == ex_dst)));
    assign mdh = id_valid & md_busy & (id_is_md | id_reads_hilo);

    assign stall    = lu | mdh;
    assign bubble   = stall;
    assign md_issue = id_valid & id_is_md & ~stall;

    assign md_busy = (state == MD_BUSY);
    assign md_done = md_busy & (md_cnt == 4'd0);

    fwd_unit u_fwd_a (
        .src           (id_rs),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dst        (ex_dst),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .fwd_data      (forward_a),
        .fwd_sel       (forward_a_sel)
    );

    fwd_unit u_fwd_b (
        .src           (id_rt),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_dst        (ex_dst),
        .ex_result     (ex_result),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .fwd_data      (forward_b),
        .fwd_sel       (forward_b_sel)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= md_cnt_nx;
        end
    end

    // An issue cannot arrive while BUSY: mdh stalls every mul/div in that state.
    always_comb begin
        state_nx  = state;
        md_cnt_nx = md_cnt;
        unique case (state)
            MD_IDLE: begin
                if (md_issue) begin
                    state_nx  = MD_BUSY;
                    md_cnt_nx = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt != 4'd0) begin
                    md_cnt_nx = md_cnt - 4'd1;
                end else begin
                    state_nx = MD_IDLE;
                end
            end
            default: begin
                state_nx  = MD_IDLE;
                md_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl (MD_LAT=4 main instance,
// MD_LAT=1 side instance sharing the same stimulus).
module tb_id_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_is_md;
    logic        id_reads_hilo;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_dst;
    logic [31:0] ex_result;
    logic        mem_reg_write;
    logic [4:0]  mem_dst;
    logic [31:0] mem_result;

    logic        stall, bubble, forward_a_sel, forward_b_sel, md_busy, md_done;
    logic [31:0] forward_a, forward_b;
    logic [3:0]  stall_cnt;

    logic        stall1, bubble1, forward_a_sel1, forward_b_sel1, md_busy1, md_done1;
    logic [31:0] forward_a1, forward_b1;
    logic [3:0]  stall_cnt1;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dst(ex_dst), .ex_result(ex_result), .mem_reg_write(mem_reg_write),
        .mem_dst(mem_dst), .mem_result(mem_result), .stall(stall), .bubble(bubble),
        .forward_a(forward_a), .forward_b(forward_b), .forward_a_sel(forward_a_sel),
        .forward_b_sel(forward_b_sel), .md_busy(md_busy), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    id_hazard_ctrl #(.MD_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dst(ex_dst), .ex_result(ex_result), .mem_reg_write(mem_reg_write),
        .mem_dst(mem_dst), .mem_result(mem_result), .stall(stall1), .bubble(bubble1),
        .forward_a(forward_a1), .forward_b(forward_b1), .forward_a_sel(forward_a_sel1),
        .forward_b_sel(forward_b_sel1), .md_busy(md_busy1), .md_done(md_done1),
        .stall_cnt(stall_cnt1)
    );

    typedef enum int {
        S_STALL, S_BUBBLE, S_FA, S_FAS, S_FB, S_FBS, S_BUSY, S_DONE, S_CNT,
        S_STALL1, S_BUSY1, S_DONE1
    } sig_e;

    typedef struct {
        sig_e        sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic logic [31:0] observe(sig_e s);
        case (s)
            S_STALL:  return {31'd0, stall};
            S_BUBBLE: return {31'd0, bubble};
            S_FA:     return forward_a;
            S_FAS:    return {31'd0, forward_a_sel};
            S_FB:     return forward_b;
            S_FBS:    return {31'd0, forward_b_sel};
            S_BUSY:   return {31'd0, md_busy};
            S_DONE:   return {31'd0, md_done};
            S_CNT:    return {28'd0, stall_cnt};
            S_STALL1: return {31'd0, stall1};
            S_BUSY1:  return {31'd0, md_busy1};
            S_DONE1:  return {31'd0, md_done1};
            default:  return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic expect_val(input sig_e s, input logic [31:0] v, input string tag);
        exp_t e;
        e.sig = s;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            tests_run++;
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_md = 0; id_reads_hilo = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0; ex_result = 0;
        mem_reg_write = 0; mem_dst = 0; mem_result = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1;
        next_cycle();
        rstn = 0;
    endtask

    task automatic load_use_on5();
        id_valid = 1; id_rs = 5; id_uses_rs = 1;
        ex_reg_write = 1; ex_mem_read = 1; ex_dst = 5; ex_result = 32'h5555_AAAA;
    endtask

    initial begin
        clear_inputs();
        rstn = 1;
        next_cycle();
        do_reset();

        // reset state
        expect_val(S_BUSY, 0, "rst_busy");
        expect_val(S_DONE, 0, "rst_done");
        expect_val(S_CNT, 0, "rst_cnt");
        expect_val(S_STALL, 0, "rst_stall");
        expect_val(S_FAS, 0, "rst_fas");
        expect_val(S_FA, 0, "rst_fa");
        expect_val(S_BUSY1, 0, "rst_busy1");
        check_all();

        // load-use stall then MEM forwarding
        next_cycle();
        load_use_on5();
        expect_val(S_STALL, 1, "lu_stall");
        expect_val(S_BUBBLE, 1, "lu_bubble");
        expect_val(S_FAS, 0, "lu_no_ex_fwd_of_load");
        check_all();
        next_cycle();
        ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0;
        mem_reg_write = 1; mem_dst = 5; mem_result = 32'hDEAD_BEEF;
        expect_val(S_STALL, 0, "lu_next_stall");
        expect_val(S_FA, 32'hDEAD_BEEF, "lu_mem_fwd_a");
        expect_val(S_FAS, 1, "lu_mem_fwd_sel");
        expect_val(S_CNT, 1, "lu_cnt");
        check_all();

        // load in EX but operand not read, or load to $0, or invalid ID
        next_cycle();
        clear_inputs();
        load_use_on5();
        id_uses_rs = 0;
        expect_val(S_STALL, 0, "lu_unused_operand");
        check_all();
        next_cycle();
        load_use_on5();
        ex_dst = 0; id_rs = 0;
        expect_val(S_STALL, 0, "lu_reg_zero");
        check_all();
        next_cycle();
        load_use_on5();
        id_valid = 0;
        expect_val(S_STALL, 0, "lu_id_invalid");
        check_all();

        // forwarding priority
        next_cycle();
        clear_inputs();
        id_valid = 1; id_rt = 3; id_uses_rt = 1; id_rs = 7; id_uses_rs = 1;
        ex_reg_write = 1; ex_dst = 3; ex_result = 32'h11;
        mem_reg_write = 1; mem_dst = 3; mem_result = 32'h22;
        expect_val(S_FB, 32'h11, "prio_fb");
        expect_val(S_FBS, 1, "prio_fbs");
        expect_val(S_FAS, 0, "prio_fas_nomatch");
        expect_val(S_STALL, 0, "prio_stall");
        check_all();
        next_cycle();
        ex_dst = 4;
        expect_val(S_FB, 32'h22, "mem_only_fb");
        expect_val(S_FBS, 1, "mem_only_fbs");
        check_all();
        next_cycle();
        id_rs = 4;
        expect_val(S_FA, 32'h11, "ex_fa");
        expect_val(S_FAS, 1, "ex_fas");
        check_all();
        next_cycle();
        ex_dst = 0; mem_dst = 0; id_rt = 0;
        expect_val(S_FBS, 0, "zero_fbs");
        expect_val(S_FB, 0, "zero_fb");
        check_all();

        // mul/div interlock: issue in cycle T, mflo from T+1
        do_reset();
        id_valid = 1; id_is_md = 1;
        expect_val(S_STALL, 0, "md_issue_stall");
        expect_val(S_BUSY, 0, "md_issue_busy");
        check_all();
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            id_is_md = 0; id_reads_hilo = 1;
            expect_val(S_BUSY, 1, "md_busy");
            expect_val(S_DONE, (i == 4) ? 32'd1 : 32'd0, "md_done");
            expect_val(S_STALL, 1, "md_mflo_stall");
            expect_val(S_CNT, 32'(i - 1), "md_cnt");
            if (i == 1) begin
                expect_val(S_BUSY1, 1, "lat1_busy");
                expect_val(S_DONE1, 1, "lat1_done");
                expect_val(S_STALL1, 1, "lat1_stall");
            end
            if (i == 2) begin
                expect_val(S_BUSY1, 0, "lat1_idle");
                expect_val(S_DONE1, 0, "lat1_done_low");
                expect_val(S_STALL1, 0, "lat1_mflo_accept");
            end
            check_all();
        end
        next_cycle();
        expect_val(S_BUSY, 0, "md_end_busy");
        expect_val(S_DONE, 0, "md_end_done");
        expect_val(S_STALL, 0, "md_mflo_accept");
        expect_val(S_CNT, 4, "md_end_cnt");
        check_all();

        // reset in the middle of BUSY
        do_reset();
        id_valid = 1; id_is_md = 1;
        check_all();
        next_cycle();
        id_is_md = 0; id_reads_hilo = 1;
        expect_val(S_STALL, 1, "rmid_stall11");
        check_all();
        next_cycle();
        rstn = 1;
        expect_val(S_BUSY, 1, "rmid_busy12");
        expect_val(S_CNT, 1, "rmid_cnt12");
        check_all();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rstn = 0;
            expect_val(S_BUSY, 0, "rmid_busy_after");
            expect_val(S_DONE, 0, "rmid_no_done");
            expect_val(S_CNT, 0, "rmid_cnt");
            check_all();
        end

        // simultaneous load-use and mul/div hazard
        do_reset();
        id_valid = 1; id_is_md = 1;
        check_all();
        next_cycle();
        id_is_md = 0; id_reads_hilo = 1;
        load_use_on5();
        expect_val(S_STALL, 1, "both_stall");
        check_all();
        next_cycle();
        clear_inputs();
        id_is_md = 1;
        expect_val(S_STALL, 0, "invalid_md_no_stall");
        expect_val(S_BUSY, 1, "both_busy_still");
        expect_val(S_CNT, 1, "both_cnt_single");
        check_all();
        for (int i = 0; i < 3; i++) next_cycle();
        expect_val(S_BUSY, 0, "both_idle_again");
        check_all();
        // mul/div held off by load-use, issues the following cycle
        next_cycle();
        load_use_on5();
        id_is_md = 1;
        expect_val(S_STALL, 1, "blocked_md_stall");
        check_all();
        next_cycle();
        ex_reg_write = 0; ex_mem_read = 0;
        expect_val(S_BUSY, 0, "blocked_md_not_issued");
        expect_val(S_STALL, 0, "blocked_md_accept");
        expect_val(S_CNT, 2, "blocked_md_cnt");
        check_all();
        next_cycle();
        clear_inputs();
        expect_val(S_BUSY, 1, "blocked_md_busy");
        check_all();

        // stall counter saturation (CNT_W = 4)
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) next_cycle();
            load_use_on5();
            expect_val(S_STALL, 1, "sat_stall");
            expect_val(S_CNT, (i > 15) ? 32'd15 : 32'(i), "sat_cnt");
            check_all();
        end

        clear_inputs();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
